// File: rtl/pixel_sink_if.sv
`default_nettype none
// ============================================================================
// Module   : pixel_sink_if
// Purpose  : Bundles the plot bus (x, y, colour, strobe), the framebuffer
//            req/ack write port and the status/error signals of pixel_sink.
//            master = producer / memory side, slave = pixel_sink.
// Ports    : vga_x[8:0], vga_y[7:0], vga_colour[2:0], vga_plot, fifo_afull,
//            fb_addr[ADDR_W-1:0], fb_data[2:0], fb_wr, fb_ack, err_clr,
//            oob_err, ovf_err, plot_count[23:0], idle
//            PIXEL_SINK_CLEAR_EN adds clr_start, clr_colour[2:0], clr_done.
// Revision : 1.0 - initial release
// ============================================================================
interface pixel_sink_if #(
    parameter int unsigned ADDR_W = 17
);
    logic [8:0]        vga_x;
    logic [7:0]        vga_y;
    logic [2:0]        vga_colour;
    logic              vga_plot;
    logic              fifo_afull;
    logic [ADDR_W-1:0] fb_addr;
    logic [2:0]        fb_data;
    logic              fb_wr;
    logic              fb_ack;
    logic              err_clr;
    logic              oob_err;
    logic              ovf_err;
    logic [23:0]       plot_count;
    logic              idle;
`ifdef PIXEL_SINK_CLEAR_EN
    logic              clr_start;
    logic [2:0]        clr_colour;
    logic              clr_done;
`endif

    modport master (
        output vga_x, vga_y, vga_colour, vga_plot, fb_ack, err_clr,
`ifdef PIXEL_SINK_CLEAR_EN
        output clr_start, clr_colour,
        input  clr_done,
`endif
        input  fifo_afull, fb_addr, fb_data, fb_wr, oob_err, ovf_err,
        input  plot_count, idle
    );

    modport slave (
        input  vga_x, vga_y, vga_colour, vga_plot, fb_ack, err_clr,
`ifdef PIXEL_SINK_CLEAR_EN
        input  clr_start, clr_colour,
        output clr_done,
`endif
        output fifo_afull, fb_addr, fb_data, fb_wr, oob_err, ovf_err,
        output plot_count, idle
    );
endinterface
`default_nettype wire

// File: rtl/pixel_sink.sv
`default_nettype none
// ============================================================================
// Module   : pixel_sink
// Purpose  : Receives plot commands, drops off-screen or overflowing pixels
//            (sticky error flags), queues the rest in a FIFO and writes each
//            one to the framebuffer at y*H_RES + x through a req/ack port.
// Ports    : clk, rst (async, active high), bus (pixel_sink_if.slave)
// Option   : define PIXEL_SINK_CLEAR_EN to add a full-screen clear engine
//            (clr_start / clr_colour / clr_done and a CLEAR state).
// Revision : 1.0 - initial release
// ============================================================================
module pixel_sink #(
    parameter int unsigned H_RES      = 320,
    parameter int unsigned V_RES      = 240,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned ADDR_W     = 17
) (
    input  wire logic   clk,
    input  wire logic   rst,
    pixel_sink_if.slave bus
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned ENTRY_W = 9 + 8 + 3;
    localparam logic [PTR_W:0] FULL_CNT  = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0] AFULL_CNT = (PTR_W+1)'(FIFO_DEPTH - 2);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1
`ifdef PIXEL_SINK_CLEAR_EN
       ,ST_CLEAR = 2'd2
`endif
    } state_t;

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
    logic [2:0]        fb_data_q, fb_data_d;
    logic              fb_wr_q, fb_wr_d;
    logic              oob_q, oob_d;
    logic              ovf_q, ovf_d;
    logic [23:0]       plot_count_q, plot_count_d;

    logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [ENTRY_W-1:0] head;
    logic [8:0]         head_x;
    logic [7:0]         head_y;
    logic [2:0]         head_c;
    logic [ADDR_W-1:0]  head_addr;

    logic fifo_empty, fifo_full, in_range, push, pop;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FULL_CNT);
    assign in_range   = (32'(bus.vga_x) < H_RES) && (32'(bus.vga_y) < V_RES);

    assign head   = fifo_mem[rd_ptr_q];
    assign head_x = head[19:11];
    assign head_y = head[10:3];
    assign head_c = head[2:0];

    // Linear address of the FIFO head; 320 = 256 + 64 avoids a multiplier.
    generate
        if (H_RES == 320) begin : g_addr_shift
            assign head_addr = (ADDR_W'(head_y) << 8) + (ADDR_W'(head_y) << 6)
                             + ADDR_W'(head_x);
        end else begin : g_addr_mul
            assign head_addr = ADDR_W'(ADDR_W'(head_y) * ADDR_W'(H_RES))
                             + ADDR_W'(head_x);
        end
    endgenerate

`ifdef PIXEL_SINK_CLEAR_EN
    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(H_RES * V_RES - 1);
    logic clr_done_q, clr_done_d;
`endif

    // ------------------------------------------------------------------
    // Write FSM: pops the FIFO and drives the req/ack port.
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        fb_addr_d    = fb_addr_q;
        fb_data_d    = fb_data_q;
        fb_wr_d      = fb_wr_q;
        plot_count_d = plot_count_q;
        pop          = 1'b0;
`ifdef PIXEL_SINK_CLEAR_EN
        clr_done_d   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    fb_addr_d = head_addr;
                    fb_data_d = head_c;
                    fb_wr_d   = 1'b1;
                    state_d   = ST_WRITE;
                end
`ifdef PIXEL_SINK_CLEAR_EN
                else if (bus.clr_start) begin
                    fb_addr_d = '0;
                    fb_data_d = bus.clr_colour;
                    fb_wr_d   = 1'b1;
                    state_d   = ST_CLEAR;
                end
`endif
            end
            ST_WRITE: begin
                if (bus.fb_ack) begin
                    plot_count_d = plot_count_q + 24'd1;
                    if (!fifo_empty) begin
                        // Back-to-back: reload on the ack edge, no bubble.
                        pop       = 1'b1;
                        fb_addr_d = head_addr;
                        fb_data_d = head_c;
                    end else begin
                        fb_wr_d = 1'b0;
                        state_d = ST_IDLE;
                    end
                end
            end
`ifdef PIXEL_SINK_CLEAR_EN
            ST_CLEAR: begin
                // The address register doubles as the clear counter.
                if (bus.fb_ack) begin
                    if (fb_addr_q == CLR_LAST) begin
                        fb_wr_d    = 1'b0;
                        clr_done_d = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        fb_addr_d = fb_addr_q + ADDR_W'(1);
                    end
                end
            end
`endif
            default: begin
                fb_wr_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Input stage: range check, overflow check, FIFO pointer update.
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    // ------------------------------------------------------------------
    always_comb begin
        push     = bus.vga_plot && in_range && (!fifo_full || pop);
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
        // A new error wins over a simultaneous clear.
        oob_d = (oob_q & ~bus.err_clr) | (bus.vga_plot & ~in_range);
        ovf_d = (ovf_q & ~bus.err_clr)
              | (bus.vga_plot & in_range & fifo_full & ~pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            fb_addr_q    <= '0;
            fb_data_q    <= '0;
            fb_wr_q      <= 1'b0;
            oob_q        <= 1'b0;
            ovf_q        <= 1'b0;
            plot_count_q <= '0;
`ifdef PIXEL_SINK_CLEAR_EN
            clr_done_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            fb_addr_q    <= fb_addr_d;
            fb_data_q    <= fb_data_d;
            fb_wr_q      <= fb_wr_d;
            oob_q        <= oob_d;
            ovf_q        <= ovf_d;
            plot_count_q <= plot_count_d;
`ifdef PIXEL_SINK_CLEAR_EN
            clr_done_q   <= clr_done_d;
`endif
        end
    end

    // FIFO storage needs no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {bus.vga_x, bus.vga_y, bus.vga_colour};
        end
    end

    assign bus.fb_addr    = fb_addr_q;
    assign bus.fb_data    = fb_data_q;
    assign bus.fb_wr      = fb_wr_q;
    assign bus.oob_err    = oob_q;
    assign bus.ovf_err    = ovf_q;
    assign bus.plot_count = plot_count_q;
    assign bus.fifo_afull = (count_q >= AFULL_CNT);
    assign bus.idle       = fifo_empty && (state_q == ST_IDLE);
`ifdef PIXEL_SINK_CLEAR_EN
    assign bus.clr_done   = clr_done_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pixel_sink.sv
`default_nettype none
// ============================================================================
// Module   : tb_pixel_sink
// Purpose  : Directed self-checking bench for pixel_sink: reset values,
//            single/corner plots, off-screen rejection, FIFO fill/overflow,
//            random ack back-pressure with ordering, and mid-write reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pixel_sink;

    logic clk;
    logic rst;

    pixel_sink_if #(.ADDR_W(17)) ps_bus ();

    pixel_sink #(
        .H_RES(320), .V_RES(240), .FIFO_DEPTH(16), .ADDR_W(17)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ps_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [16:0] a;
        logic [2:0]  d;
    } pix_t;

    pix_t exp_q[$];
    int   n_checks = 0;
    int   n_err    = 0;
    int   n_writes = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Write monitor: every accepted write must match the next expected pixel,
    // and a pending (unacked) write must hold address and data stable.
    logic        hold_pend = 1'b0;
    logic [16:0] hold_addr;
    logic [2:0]  hold_data;

    always @(posedge clk) begin
        if (rst) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                check("hold_wr",   32'(ps_bus.fb_wr),   32'd1);
                check("hold_addr", 32'(ps_bus.fb_addr), 32'(hold_addr));
                check("hold_data", 32'(ps_bus.fb_data), 32'(hold_data));
            end
            if (ps_bus.fb_wr && ps_bus.fb_ack) begin
                n_writes++;
                if (exp_q.size() == 0) begin
                    check("unexpected_wr", 32'd1, 32'd0);
                end else begin
                    pix_t e;
                    e = exp_q.pop_front();
                    check("wr_addr", 32'(ps_bus.fb_addr), 32'(e.a));
                    check("wr_data", 32'(ps_bus.fb_data), 32'(e.d));
                end
            end
            hold_pend = ps_bus.fb_wr && !ps_bus.fb_ack;
            hold_addr = ps_bus.fb_addr;
            hold_data = ps_bus.fb_data;
        end
    end

    task automatic expect_pix(input int x, input int y, input logic [2:0] c);
        pix_t p;
        p.a = 17'(y * 320 + x);
        p.d = c;
        exp_q.push_back(p);
    endtask

    // Drive one plot at the current negedge; returns after the sampling edge.
    task automatic plot(input int x, input int y, input logic [2:0] c);
        ps_bus.vga_x      = 9'(x);
        ps_bus.vga_y      = 8'(y);
        ps_bus.vga_colour = c;
        ps_bus.vga_plot   = 1'b1;
        @(negedge clk);
        ps_bus.vga_plot   = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (!(ps_bus.idle && exp_q.size() == 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        int w0;
        int sent;
        rst               = 1'b1;
        ps_bus.vga_x      = '0;
        ps_bus.vga_y      = '0;
        ps_bus.vga_colour = '0;
        ps_bus.vga_plot   = 1'b0;
        ps_bus.fb_ack     = 1'b1;
        ps_bus.err_clr    = 1'b0;
        repeat (3) @(negedge clk);

        // Reset values
        check("rst_fb_wr",   32'(ps_bus.fb_wr),      32'd0);
        check("rst_fb_addr", 32'(ps_bus.fb_addr),    32'd0);
        check("rst_idle",    32'(ps_bus.idle),       32'd1);
        check("rst_afull",   32'(ps_bus.fifo_afull), 32'd0);
        check("rst_errs",    32'({ps_bus.oob_err, ps_bus.ovf_err}), 32'd0);
        check("rst_count",   32'(ps_bus.plot_count), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single plot (5,2,5): 2*320+5 = 645, visible one edge after sampling
        expect_pix(5, 2, 3'b101);
        plot(5, 2, 3'b101);
        @(negedge clk);
        check("lat_fb_wr",   32'(ps_bus.fb_wr),   32'd1);
        check("lat_fb_addr", 32'(ps_bus.fb_addr), 32'd645);
        check("lat_fb_data", 32'(ps_bus.fb_data), 32'd5);
        wait_idle("single", 50);
        check("single_count", 32'(ps_bus.plot_count), 32'd1);
        check("single_idle",  32'(ps_bus.idle),       32'd1);

        // Corners: addresses 0 and 76799
        expect_pix(0, 0, 3'd1);
        expect_pix(319, 239, 3'd6);
        plot(0, 0, 3'd1);
        plot(319, 239, 3'd6);
        wait_idle("corner", 50);
        check("corner_count", 32'(ps_bus.plot_count), 32'd3);

        // Off-screen plots are dropped
        w0 = n_writes;
        plot(320, 0, 3'd7);
        plot(0, 240, 3'd7);
        repeat (3) @(negedge clk);
        check("oob_flag",   32'(ps_bus.oob_err), 32'd1);
        check("oob_nowr",   32'(n_writes - w0),  32'd0);
        check("oob_noovf",  32'(ps_bus.ovf_err), 32'd0);
        ps_bus.err_clr = 1'b1;
        @(negedge clk);
        ps_bus.err_clr = 1'b0;
        check("oob_clr",    32'(ps_bus.oob_err), 32'd0);
        // Clear coinciding with a new error leaves the flag set
        ps_bus.err_clr = 1'b1;
        plot(400, 10, 3'd2);
        ps_bus.err_clr = 1'b0;
        check("oob_clr_race", 32'(ps_bus.oob_err), 32'd1);
        ps_bus.err_clr = 1'b1;
        @(negedge clk);
        ps_bus.err_clr = 1'b0;
        check("oob_clr2",   32'(ps_bus.oob_err), 32'd0);

        // Fill with ack low: the writer holds plot 1, the FIFO takes plots
        // 2..17 (occupancy after plot k is k-1), plot 18 overflows.
        ps_bus.fb_ack = 1'b0;
        w0 = n_writes;
        for (int i = 1; i <= 18; i++) begin
            if (i <= 17) expect_pix(i, 3, 3'(i));
            plot(i, 3, 3'(i));
            if (i == 14) check("afull_lo_14", 32'(ps_bus.fifo_afull), 32'd0);
            if (i == 15) check("afull_hi_15", 32'(ps_bus.fifo_afull), 32'd1);
            if (i == 17) check("ovf_lo_17",   32'(ps_bus.ovf_err),    32'd0);
            if (i == 18) check("ovf_hi_18",   32'(ps_bus.ovf_err),    32'd1);
        end
        check("fill_nowr", 32'(n_writes - w0), 32'd0);
        ps_bus.fb_ack = 1'b1;
        wait_idle("fill", 100);
        check("fill_writes", 32'(n_writes - w0),     32'd17);
        check("fill_count",  32'(ps_bus.plot_count), 32'd20);
        ps_bus.err_clr = 1'b1;
        @(negedge clk);
        ps_bus.err_clr = 1'b0;
        check("ovf_clr", 32'(ps_bus.ovf_err), 32'd0);

        // Random ack gaps, 100 in-range plots paced by fifo_afull
        w0   = n_writes;
        sent = 0;
        while (sent < 100) begin
            ps_bus.fb_ack = (($urandom % 3) != 0);
            if (!ps_bus.fifo_afull && ($urandom % 4) != 0) begin
                int x;
                int y;
                logic [2:0] c;
                x = int'($urandom_range(0, 319));
                y = int'($urandom_range(0, 239));
                c = 3'($urandom);
                expect_pix(x, y, c);
                ps_bus.vga_x      = 9'(x);
                ps_bus.vga_y      = 8'(y);
                ps_bus.vga_colour = c;
                ps_bus.vga_plot   = 1'b1;
                sent++;
            end else begin
                ps_bus.vga_plot = 1'b0;
            end
            @(negedge clk);
        end
        ps_bus.vga_plot = 1'b0;
        ps_bus.fb_ack   = 1'b1;
        wait_idle("rand", 400);
        check("rand_writes", 32'(n_writes - w0),     32'd100);
        check("rand_count",  32'(ps_bus.plot_count), 32'd120);
        check("rand_noerr",  32'({ps_bus.oob_err, ps_bus.ovf_err}), 32'd0);

        // Reset mid-write with 5 entries queued
        ps_bus.fb_ack = 1'b0;
        for (int i = 0; i < 6; i++) begin
            expect_pix(10 + i, 20, 3'd3);
            plot(10 + i, 20, 3'd3);
        end
        @(negedge clk);
        check("prerst_wr", 32'(ps_bus.fb_wr), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_fb_wr",  32'(ps_bus.fb_wr),      32'd0);
        check("arst_addr",   32'(ps_bus.fb_addr),    32'd0);
        check("arst_data",   32'(ps_bus.fb_data),    32'd0);
        check("arst_count",  32'(ps_bus.plot_count), 32'd0);
        check("arst_idle",   32'(ps_bus.idle),       32'd1);
        check("arst_afull",  32'(ps_bus.fifo_afull), 32'd0);
        exp_q.delete();
        w0 = n_writes;
        @(negedge clk);
        rst           = 1'b0;
        ps_bus.fb_ack = 1'b1;
        repeat (10) @(negedge clk);
        check("postrst_nowr",  32'(n_writes - w0),     32'd0);
        check("postrst_idle",  32'(ps_bus.idle),       32'd1);
        check("postrst_count", 32'(ps_bus.plot_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

    // Absolute backstop so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout observed=0 expected=1");
        $fatal(1, "global timeout");
    end

endmodule
`default_nettype wire
